mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the core's instruction-fetch and load/store requesters.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_port_arbiter: requester ownership and arbiter FSM state.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Pure winner select between masked fetch and data requests.
// MEM_ARB_RR_EN selects round-robin; otherwise data-first with starvation override.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_req_m,
   input  logic   d_req_m,
`ifdef MEM_ARB_RR_EN
   input  owner_e last_grant,
`else
   input  logic   starve_hit,
`endif
   output owner_e winner
);

   always_comb begin
      winner = OWN_NONE;
      if (i_req_m && d_req_m) begin
`ifdef MEM_ARB_RR_EN
         winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
`else
         winner = starve_hit ? OWN_I : OWN_D;
`endif
      end else if (d_req_m) begin
         winner = OWN_D;
      end else if (i_req_m) begin
         winner = OWN_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store requesters; all outputs registered.
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of data priority plus starve counter.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [AW-1:0]     i_addr,
   output logic [DW-1:0]     i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [DW-1:0]     d_wdata,
   input  logic [DW/8-1:0]   d_be,
   output logic [DW-1:0]     d_rdata,
   output logic              d_ack,
   output logic              m_req,
   output logic              m_we,
   output logic [AW-1:0]     m_addr,
   output logic [DW-1:0]     m_wdata,
   output logic [DW/8-1:0]   m_be,
   input  logic              m_ack,
   input  logic [DW-1:0]     m_rdata,
   output logic [1:0]        owner
);

   localparam int BW = DW / 8;

   arb_state_e      r_state;
   owner_e          r_owner;
   logic            r_m_req;
   logic            r_m_we;
   logic [AW-1:0]   r_m_addr;
   logic [DW-1:0]   r_m_wdata;
   logic [BW-1:0]   r_m_be;
   logic            r_i_ack;
   logic            r_d_ack;
   logic [DW-1:0]   r_i_rdata;
   logic [DW-1:0]   r_d_rdata;

   logic            w_i_req_m;
   logic            w_d_req_m;
   logic            w_idle;
   owner_e          w_winner;

   // A requester still holding req during its own ack cycle is not re-granted.
   assign w_i_req_m = i_req & ~r_i_ack;
   assign w_d_req_m = d_req & ~r_d_ack;
   assign w_idle    = (r_state == IDLE);

`ifdef MEM_ARB_RR_EN
   owner_e r_last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= OWN_I;
      end else if (w_idle && (w_winner != OWN_NONE)) begin
         r_last_grant <= w_winner;
      end
   end

   mem_arb_pick u_pick (
      .i_req_m    (w_i_req_m),
      .d_req_m    (w_d_req_m),
      .last_grant (r_last_grant),
      .winner     (w_winner)
   );
`else
   localparam int            SW         = $clog2(MAX_WAIT + 1);
   localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);

   logic [SW-1:0] r_starve;
   logic          w_starve_hit;

   assign w_starve_hit = (r_starve == MAX_WAIT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
      end else if (w_idle) begin
         if ((w_winner == OWN_I) || !i_req) begin
            r_starve <= '0;
         end else if ((w_winner == OWN_D) && w_i_req_m && !w_starve_hit) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end

   mem_arb_pick u_pick (
      .i_req_m    (w_i_req_m),
      .d_req_m    (w_d_req_m),
      .starve_hit (w_starve_hit),
      .winner     (w_winner)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_owner   <= OWN_NONE;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_be    <= '0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_winner == OWN_I) begin
                  r_m_req   <= 1'b1;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= i_addr;
                  r_m_wdata <= '0;
                  r_m_be    <= '1;
                  r_owner   <= OWN_I;
                  r_state   <= BUSY_I;
               end else if (w_winner == OWN_D) begin
                  r_m_req   <= 1'b1;
                  r_m_we    <= d_we;
                  r_m_addr  <= d_addr;
                  r_m_wdata <= d_we ? d_wdata : '0;
                  r_m_be    <= d_we ? d_be : '1;
                  r_owner   <= OWN_D;
                  r_state   <= BUSY_D;
               end
            end
            BUSY_I: begin
               if (m_ack) begin
                  r_i_ack   <= 1'b1;
                  r_i_rdata <= m_rdata;
                  r_m_req   <= 1'b0;
                  r_m_we    <= 1'b0;
                  r_owner   <= OWN_NONE;
                  r_state   <= IDLE;
               end
            end
            BUSY_D: begin
               if (m_ack) begin
                  r_d_ack <= 1'b1;
                  if (!r_m_we) begin
                     r_d_rdata <= m_rdata;
                  end
                  r_m_req <= 1'b0;
                  r_m_we  <= 1'b0;
                  r_owner <= OWN_NONE;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign i_rdata = r_i_rdata;
   assign i_ack   = r_i_ack;
   assign d_rdata = r_d_rdata;
   assign d_ack   = r_d_ack;
   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign m_be    = r_m_be;
   assign owner   = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: rule-level reference model feeds expectation queues,
// an independent monitor pops them as the DUT issues commands and acks.
module tb_mem_port_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int BW       = DW / 8;
   localparam int MAX_WAIT = 4;
   localparam int NCYC     = 4000;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_req;
   logic [AW-1:0]   i_addr;
   logic [DW-1:0]   i_rdata;
   logic            i_ack;
   logic            d_req;
   logic            d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [BW-1:0]   d_be;
   logic [DW-1:0]   d_rdata;
   logic            d_ack;
   logic            m_req;
   logic            m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [BW-1:0]   m_be;
   logic            m_ack;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      owner;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata), .owner(owner)
   );

   typedef struct {
      int            cyc;
      logic [1:0]    own;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } cmd_t;

   typedef struct {
      int            cyc;
      logic [DW-1:0] rdata;
   } rsp_t;

   cmd_t exp_cmd[$];
   rsp_t exp_i[$];
   rsp_t exp_d[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: one arbitration decision per free cycle, from the requests visible that edge.
   initial begin : model
      int            busy;
      bit            ack_i, ack_d, nack_i, nack_d, im, dm;
      int            win;
      logic          cur_we;
      logic [DW-1:0] drd;
      cmd_t          c;
      rsp_t          r;
`ifdef MEM_ARB_RR_EN
      int            last;
`else
      int            starve;
`endif
      busy = 0; ack_i = 0; ack_d = 0; cur_we = 0; drd = '0;
`ifdef MEM_ARB_RR_EN
      last = 1;
`else
      starve = 0;
`endif
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            busy = 0; ack_i = 0; ack_d = 0; drd = '0;
`ifdef MEM_ARB_RR_EN
            last = 1;
`else
            starve = 0;
`endif
         end else begin
            nack_i = 0;
            nack_d = 0;
            if (busy == 0) begin
               im  = i_req && !ack_i;
               dm  = d_req && !ack_d;
               win = 0;
               if (im && dm) begin
`ifdef MEM_ARB_RR_EN
                  win = (last == 2) ? 1 : 2;
`else
                  win = (starve == MAX_WAIT) ? 1 : 2;
`endif
               end else if (dm) win = 2;
               else if (im) win = 1;
`ifdef MEM_ARB_RR_EN
               if (win != 0) last = win;
`else
               if (win == 1 || !i_req) starve = 0;
               else if (win == 2 && im && starve < MAX_WAIT) starve++;
`endif
               if (win == 1) begin
                  c.cyc = cyc; c.own = 2'd1; c.we = 1'b0; c.addr = i_addr;
                  c.wdata = '0; c.be = '1;
                  exp_cmd.push_back(c);
               end else if (win == 2) begin
                  c.cyc = cyc; c.own = 2'd2; c.we = d_we; c.addr = d_addr;
                  c.wdata = d_we ? d_wdata : '0;
                  c.be = d_we ? d_be : '1;
                  cur_we = d_we;
                  exp_cmd.push_back(c);
               end
               busy = win;
            end else if (m_ack) begin
               if (busy == 1) begin
                  r.cyc = cyc; r.rdata = m_rdata;
                  exp_i.push_back(r);
                  nack_i = 1;
               end else begin
                  if (!cur_we) drd = m_rdata;
                  r.cyc = cyc; r.rdata = drd;
                  exp_d.push_back(r);
                  nack_d = 1;
               end
               busy = 0;
            end
            ack_i = nack_i;
            ack_d = nack_d;
         end
      end
   end

   // Monitor: pops expectations when the DUT presents a new command or an ack pulse.
   initial begin : monitor
      bit   pm;
      cmd_t cur, e;
      rsp_t r;
      pm = 0;
      cur.cyc = 0; cur.own = '0; cur.we = 0; cur.addr = '0; cur.wdata = '0; cur.be = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            check("reset_outputs_a", {m_req, m_we, m_addr, m_wdata, m_be, owner}, '0);
            check("reset_outputs_b", {i_ack, d_ack, i_rdata, d_rdata}, '0);
            pm = 0;
         end else begin
            if (m_req && !pm) begin
               check("grant_expected", exp_cmd.size() > 0, 1);
               if (exp_cmd.size() > 0) begin
                  e = exp_cmd.pop_front();
                  check("grant_cycle", cyc, e.cyc);
                  check("grant_cmd", {owner, m_we, m_addr, m_wdata, m_be},
                        {e.own, e.we, e.addr, e.wdata, e.be});
                  cur = e;
               end
            end else if (m_req && pm) begin
               check("hold_cmd", {owner, m_we, m_addr, m_wdata, m_be},
                     {cur.own, cur.we, cur.addr, cur.wdata, cur.be});
            end else begin
               check("idle_owner", {owner, m_we}, '0);
            end
            if (i_ack) begin
               check("i_ack_expected", exp_i.size() > 0, 1);
               if (exp_i.size() > 0) begin
                  r = exp_i.pop_front();
                  check("i_ack_cycle", cyc, r.cyc);
                  check("i_rdata", i_rdata, r.rdata);
               end
            end
            if (d_ack) begin
               check("d_ack_expected", exp_d.size() > 0, 1);
               if (exp_d.size() > 0) begin
                  r = exp_d.pop_front();
                  check("d_ack_cycle", cyc, r.cyc);
                  check("d_rdata", d_rdata, r.rdata);
               end
            end
            pm = m_req;
         end
      end
   end

   // Stimulus: two requesters and a memory with random wait states and idle ack noise.
   initial begin : stim
      int iw, dw, ig, dg, mwait;
      bit iwait, dwait, mact, rst_done, late;
      iw = 0; dw = 0; ig = 0; dg = 0; mwait = 0;
      iwait = 0; dwait = 0; mact = 0; rst_done = 0; late = 0;
      rst = 1'b1;
      i_req = 0; i_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
      m_ack = 0; m_rdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < NCYC; n++) begin
         @(negedge clk);
         m_ack = 1'b0;
         if (rst) begin
            rst  = 1'b0;
            late = 1;
         end
         if (iwait && i_ack) begin
            iwait = 0; i_req = 0; ig = $urandom_range(0, 2);
         end
         if (!iwait && n < NCYC - 200) begin
            if (ig == 0) begin
               i_req = 1; i_addr = $urandom; iwait = 1; iw = 0;
            end else ig--;
         end
         if (iwait) begin
            iw++;
            if (iw > 100) begin
               check("fetch_timeout", iw, 100);
               iwait = 0; i_req = 0; ig = 1;
            end
         end
         if (dwait && d_ack) begin
            dwait = 0; d_req = 0; dg = $urandom_range(0, 2);
         end
         if (!dwait && n < NCYC - 200) begin
            if (dg == 0) begin
               d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom;
               d_wdata = $urandom; d_be = BW'($urandom); dwait = 1; dw = 0;
            end else dg--;
         end
         if (dwait) begin
            dw++;
            if (dw > 100) begin
               check("data_timeout", dw, 100);
               dwait = 0; d_req = 0; dg = 1;
            end
         end
         if (late) begin
            m_ack = 1'b1; m_rdata = $urandom; late = 0;
         end else if (m_req) begin
            if (!mact) begin
               mact = 1; mwait = $urandom_range(0, 3);
            end
            if (mwait == 0) begin
               m_ack = 1'b1; m_rdata = $urandom; mact = 0;
            end else mwait--;
         end else if ($urandom_range(0, 7) == 0) begin
            m_ack = 1'b1; m_rdata = $urandom;
         end
         // Abort a data access mid-flight; the ack arriving after reset must be ignored.
         if (!rst_done && n > 1000 && owner == 2'd2 && m_req) begin
            rst = 1'b1; rst_done = 1; m_ack = 1'b0; mact = 0;
            i_req = 0; d_req = 0; iwait = 0; dwait = 0; ig = 1; dg = 1;
         end
      end
      repeat (10) @(negedge clk);
      check("reset_injected", rst_done, 1);
      check("cmd_queue_drained", exp_cmd.size(), 0);
      check("i_queue_drained", exp_i.size(), 0);
      check("d_queue_drained", exp_d.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
